// File: rtl/atm_pkg.sv
// Shared definitions for the ATM card/keypad front-end and the transaction FSM downstream.
// Key codes, entry-state encoding and word widths.
package atm_pkg;

    localparam int DIGITS = 3;
    localparam int WORD_W = 12;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_BACK   = 4'hB;
    localparam logic [3:0] KEY_ENTER  = 4'hC;
    localparam logic [3:0] KEY_CANCEL = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCT      = 3'd1,
        ST_PIN       = 3'd2,
        ST_WAIT_AUTH = 3'd3,
        ST_SESSION   = 3'd4,
        ST_EJECT     = 3'd5,
        ST_LOCKED    = 3'd6
    } entry_state_e;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_digit_buffer.sv
// Three-nibble BCD entry buffer: push shifts a digit in from the right, pop drops the last one.
// Clear wins over push, push over pop; full pushes and empty pops are ignored.
module atm_digit_buffer
    import atm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [3:0]        digit,
    output logic [WORD_W-1:0] data,
    output logic [1:0]        count
);

    logic [WORD_W-1:0] data_q, data_d;
    logic [1:0]        count_q, count_d;

    // NOTE: defaults first so every path assigns every output -- otherwise a latch is inferred.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (clear) begin
            data_d  = '0;
            count_d = '0;
        end else if (push && count_q < 2'(DIGITS)) begin
            data_d  = {data_q[WORD_W-5:0], digit};
            count_d = count_q + 2'd1;
        end else if (pop && count_q != 2'd0) begin
            data_d  = {4'd0, data_q[WORD_W-1:4]};
            count_d = count_q - 2'd1;
        end
    end

    // NOTE: non-blocking (<=) in clocked blocks so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign data  = data_q;
    assign count = count_q;

endmodule

// File: rtl/atm_keypad_entry.sv
// ATM card/keypad front-end: collects account and PIN, tracks retries, lockout,
// inactivity timeout and card eject. All outputs come straight from flops.
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_TRIES      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              card_in,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              auth_done,
    input  logic              auth_ok,
    output logic [WORD_W-1:0] acct_number,
    output logic [WORD_W-1:0] pin,
    output logic              acct_valid,
    output logic              pin_valid,
    output logic              session_active,
    output logic              card_eject,
    output logic              locked,
    output logic [1:0]        digit_count
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    entry_state_e      state_q, state_d;
    logic              card_prev_q;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [2:0]        retry_q, retry_d;
    logic [WORD_W-1:0] acct_q, acct_d, pin_q, pin_d;
    logic              acct_valid_q, acct_valid_d, pin_valid_q, pin_valid_d;
    logic              session_q, session_d, eject_q, eject_d, locked_q, locked_d;

    logic              buf_push, buf_pop, buf_clear;
    logic [WORD_W-1:0] buf_data;
    logic [1:0]        buf_count;

    logic in_entry, active, card_rise, card_fall, cancel, key_act;
    logic enter_ok, auth_ev, timed_out, clear_session;
    logic [2:0] retry_inc;

    // Event decode in priority order: card fall > cancel > auth verdict > key > timeout.
    assign in_entry  = (state_q == ST_ACCT) || (state_q == ST_PIN);
    assign active    = in_entry || (state_q == ST_WAIT_AUTH) || (state_q == ST_SESSION);
    assign card_rise = card_in && !card_prev_q;
    assign card_fall = !card_in && card_prev_q && active;
    assign cancel    = active && !card_fall && key_valid && (key_code == KEY_CANCEL);
    assign key_act   = in_entry && !card_fall && key_valid;
    assign enter_ok  = key_act && (key_code == KEY_ENTER) && (buf_count == 2'(DIGITS));
    assign auth_ev   = (state_q == ST_WAIT_AUTH) && !card_fall && !cancel && auth_done;
    assign timed_out = in_entry && !card_fall && !key_valid
                       && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign retry_inc = retry_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            card_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            card_prev_q <= card_in;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                if (card_rise) state_d = ST_ACCT;
            ST_ACCT, ST_PIN: begin
                if (card_fall)      state_d = ST_IDLE;
                else if (cancel)    state_d = ST_EJECT;
                else if (enter_ok)  state_d = (state_q == ST_ACCT) ? ST_PIN : ST_WAIT_AUTH;
                else if (timed_out) state_d = ST_EJECT;
            end
            ST_WAIT_AUTH: begin
                if (card_fall)   state_d = ST_IDLE;
                else if (cancel) state_d = ST_EJECT;
                else if (auth_ev) begin
                    if (auth_ok)                         state_d = ST_SESSION;
                    else if (retry_inc == 3'(MAX_TRIES)) state_d = ST_LOCKED;
                    else                                 state_d = ST_PIN;
                end
            end
            ST_SESSION: begin
                if (card_fall)   state_d = ST_IDLE;
                else if (cancel) state_d = ST_EJECT;
            end
            ST_EJECT:
                if (!card_in) state_d = ST_IDLE;
            ST_LOCKED:
                state_d = ST_LOCKED;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clear_session = card_fall || (state_d == ST_EJECT && state_q != ST_EJECT);
        buf_push      = key_act && is_digit(key_code);
        buf_pop       = key_act && (key_code == KEY_BACK);
        buf_clear     = clear_session || enter_ok || (key_act && key_code == KEY_CLEAR);

        acct_d       = acct_q;
        acct_valid_d = acct_valid_q;
        pin_d        = pin_q;
        pin_valid_d  = 1'b0;
        retry_d      = retry_q;

        if (enter_ok && state_q == ST_ACCT) begin
            acct_d       = buf_data;
            acct_valid_d = 1'b1;
        end
        if (enter_ok && state_q == ST_PIN) begin
            pin_d       = buf_data;
            pin_valid_d = 1'b1;
        end
        if (auth_ev) begin
            pin_d   = '0;
            retry_d = auth_ok ? 3'd0 : retry_inc;
        end
        if (state_d == ST_LOCKED) begin
            acct_d = '0;
            pin_d  = '0;
        end
        if (clear_session) begin
            acct_d       = '0;
            acct_valid_d = 1'b0;
            pin_d        = '0;
            retry_d      = '0;
        end

        // Restart the inactivity timer on any key or state change; it idles outside entry.
        if (state_d != state_q || key_valid || !in_entry) timer_d = '0;
        else                                              timer_d = timer_q + TMR_W'(1);

        session_d = (state_d == ST_SESSION);
        eject_d   = (state_d == ST_EJECT);
        locked_d  = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q      <= '0;
            retry_q      <= '0;
            acct_q       <= '0;
            acct_valid_q <= 1'b0;
            pin_q        <= '0;
            pin_valid_q  <= 1'b0;
            session_q    <= 1'b0;
            eject_q      <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            acct_q       <= acct_d;
            acct_valid_q <= acct_valid_d;
            pin_q        <= pin_d;
            pin_valid_q  <= pin_valid_d;
            session_q    <= session_d;
            eject_q      <= eject_d;
            locked_q     <= locked_d;
        end
    end

    atm_digit_buffer u_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (buf_push),
        .pop   (buf_pop),
        .clear (buf_clear),
        .digit (key_code),
        .data  (buf_data),
        .count (buf_count)
    );

    assign acct_number    = acct_q;
    assign pin            = pin_q;
    assign acct_valid     = acct_valid_q;
    assign pin_valid      = pin_valid_q;
    assign session_active = session_q;
    assign card_eject     = eject_q;
    assign locked         = locked_q;
    assign digit_count    = buf_count;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Bench for atm_keypad_entry: directed scenarios plus random keypad/card traffic,
// all outputs compared every cycle against a digit-queue reference model.
module tb_atm_keypad_entry;

    localparam int TIMEOUT = 20;
    localparam int TRIES   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        card_in = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        auth_done = 1'b0;
    logic        auth_ok = 1'b0;
    logic [11:0] acct_number, pin;
    logic        acct_valid, pin_valid, session_active, card_eject, locked;
    logic [1:0]  digit_count;

    atm_keypad_entry #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_TRIES(TRIES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .card_in        (card_in),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .auth_done      (auth_done),
        .auth_ok        (auth_ok),
        .acct_number    (acct_number),
        .pin            (pin),
        .acct_valid     (acct_valid),
        .pin_valid      (pin_valid),
        .session_active (session_active),
        .card_eject     (card_eject),
        .locked         (locked),
        .digit_count    (digit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total_checks = 0;
    int bad_checks   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: session phase plus a queue of typed digits.
    typedef enum {M_IDLE, M_ACCT, M_PIN, M_WAIT, M_SESS, M_EJECT, M_LOCK} m_state_e;
    m_state_e m_st;
    int       m_digits[$];
    int       m_acct, m_pin, m_tries, m_idle;
    bit       m_acct_valid, m_pin_valid, m_card_prev;
    bit       card_cur;

    function automatic void model_reset();
        m_st = M_IDLE; m_digits.delete(); m_acct = 0; m_pin = 0; m_tries = 0;
        m_idle = 0; m_acct_valid = 0; m_pin_valid = 0; m_card_prev = 0;
    endfunction

    function automatic void wipe();
        m_acct = 0; m_pin = 0; m_acct_valid = 0; m_digits.delete(); m_tries = 0;
    endfunction

    function automatic int digits_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return v;
    endfunction

    function automatic void model_step(input bit c, input bit kv, input int k,
                                       input bit ad, input bit ao);
        m_state_e nxt = m_st;
        bit entry  = (m_st == M_ACCT) || (m_st == M_PIN);
        bit act    = entry || (m_st == M_WAIT) || (m_st == M_SESS);
        bit fall   = m_card_prev && !c;
        bit rise   = !m_card_prev && c;
        m_pin_valid = 0;
        m_card_prev = c;
        if (act && fall) begin
            nxt = M_IDLE; wipe();
        end else if (act && kv && k == 13) begin
            nxt = M_EJECT; wipe();
        end else begin
            case (m_st)
                M_IDLE:  if (rise) nxt = M_ACCT;
                M_EJECT: if (!c) nxt = M_IDLE;
                M_WAIT: if (ad) begin
                    m_pin = 0;
                    if (ao) begin
                        nxt = M_SESS; m_tries = 0;
                    end else begin
                        m_tries++;
                        if (m_tries == TRIES) begin
                            nxt = M_LOCK; m_acct = 0;
                        end else nxt = M_PIN;
                    end
                end
                M_ACCT, M_PIN: begin
                    if (kv) begin
                        m_idle = 0;
                        if (k <= 9) begin
                            if (m_digits.size() < 3) m_digits.push_back(k);
                        end else if (k == 10) m_digits.delete();
                        else if (k == 11) begin
                            if (m_digits.size() > 0) void'(m_digits.pop_back());
                        end else if (k == 12 && m_digits.size() == 3) begin
                            if (m_st == M_ACCT) begin
                                m_acct = digits_value(); m_acct_valid = 1; nxt = M_PIN;
                            end else begin
                                m_pin = digits_value(); m_pin_valid = 1; nxt = M_WAIT;
                            end
                            m_digits.delete();
                        end
                    end else begin
                        m_idle++;
                        if (m_idle >= TIMEOUT) begin
                            nxt = M_EJECT; wipe();
                        end
                    end
                end
                default: ;
            endcase
        end
        if (nxt != m_st) m_idle = 0;
        m_st = nxt;
    endfunction

    task automatic compare_all();
        check("acct_number", acct_number, m_acct);
        check("pin", pin, m_pin);
        check("acct_valid", acct_valid, m_acct_valid);
        check("pin_valid", pin_valid, m_pin_valid);
        check("session_active", session_active, m_st == M_SESS);
        check("card_eject", card_eject, m_st == M_EJECT);
        check("locked", locked, m_st == M_LOCK);
        check("digit_count", digit_count, m_digits.size());
    endtask

    // Called at a negedge: drive inputs, advance model and DUT one edge, compare.
    task automatic step(input bit c, input bit kv, input int k, input bit ad, input bit ao);
        card_in = c; key_valid = kv; key_code = 4'(k); auth_done = ad; auth_ok = ao;
        model_step(c, kv, k, ad, ao);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        step(card_cur, 0, 0, 0, 0);
    endtask

    task automatic key(input int k);
        step(card_cur, 1, k, 0, 0);
    endtask

    task automatic keys(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    // Asynchronous reset asserted between edges; outputs must drop before the next edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int ek[7]  = '{7, 8, 11, 9, 9, 9, 12};
        int ec[7]  = '{1, 2, 1, 2, 3, 3, 0};

        model_reset();
        card_cur = 0;
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Happy path
        card_cur = 1; idle();
        keys(1, 2, 3, 12);
        check("hp_acct", acct_number, 12'h123);
        keys(4, 5, 6, 12);
        check("hp_pin_valid", pin_valid, 1);
        check("hp_pin", pin, 12'h456);
        idle();
        check("hp_pin_valid_once", pin_valid, 0);
        step(1, 0, 0, 1, 1);
        check("hp_session", session_active, 1);
        key(13);
        check("hp_eject", card_eject, 1);
        card_cur = 0; idle();
        check("hp_idle", card_eject, 0);

        // Edit keys
        card_cur = 1; idle();
        for (int i = 0; i < 7; i++) begin
            key(ek[i]);
            if (i < 6) check("edit_count", digit_count, ec[i]);
        end
        check("edit_acct", acct_number, 12'h799);
        key(1); key(2); key(12);
        check("edit_short_enter", digit_count, 2);
        check("edit_no_pin_valid", pin_valid, 0);
        key(10);
        check("edit_clear", digit_count, 0);
        key(13);
        card_cur = 0; idle();

        // Timeout with no keys
        card_cur = 1; idle();
        n = 0;
        while (!card_eject && n < 100) begin idle(); n++; end
        check("timeout_cycles", n, TIMEOUT);
        card_cur = 0; idle();

        // Timeout delayed by a digit at cycle 15
        card_cur = 1; idle();
        for (int i = 0; i < 14; i++) idle();
        key(5);
        n = 15;
        while (!card_eject && n < 100) begin idle(); n++; end
        check("timeout_delayed", n, 35);
        card_cur = 0; idle();

        // Lockout after three wrong PINs
        card_cur = 1; idle();
        keys(1, 2, 3, 12);
        for (int t = 0; t < TRIES; t++) begin
            keys(4, 5, 6, 12);
            step(1, 0, 0, 1, 0);
            check("lock_state", locked, t == TRIES - 1);
        end
        check("lock_no_eject", card_eject, 0);
        card_cur = 0; idle();
        check("lock_card_ignored", locked, 1);
        do_reset();
        check("lock_reset", locked, 0);

        // Cancel wins over auth verdict
        card_cur = 1; idle();
        keys(1, 2, 3, 12); keys(4, 5, 6, 12);
        step(1, 1, 13, 1, 1);
        check("simul_eject", card_eject, 1);
        check("simul_no_session", session_active, 0);
        card_cur = 0; idle();

        // Card fall wins over enter
        card_cur = 1; idle();
        keys(1, 2, 3, 12); key(4); key(5); key(6);
        card_cur = 0;
        step(0, 1, 12, 0, 0);
        check("fall_no_pin_valid", pin_valid, 0);
        check("fall_acct_cleared", acct_valid, 0);

        // Reset mid-PIN, card held through release
        card_cur = 1; idle();
        keys(1, 2, 3, 12); key(7); key(8);
        check("midpin_count", digit_count, 2);
        do_reset();
        idle();
        keys(4, 5, 6, 12);
        check("midpin_reacct", acct_number, 12'h456);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r, k;
            bit kv, ad, ao;
            if ((locked && $urandom_range(9) == 0) || (i % 600 == 599)) do_reset();
            if (card_cur) begin
                if ($urandom_range(99) < 2) card_cur = 0;
            end else if ($urandom_range(99) < 30) card_cur = 1;
            kv = $urandom_range(1);
            r  = $urandom_range(99);
            if (r < 60)      k = $urandom_range(9);
            else if (r < 75) k = 12;
            else if (r < 82) k = 11;
            else if (r < 86) k = 10;
            else if (r < 88) k = 13;
            else             k = $urandom_range(15, 14);
            ad = ($urandom_range(9) == 0);
            ao = $urandom_range(1);
            step(card_cur, kv, k, ad, ao);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

Card and keypad front-end that sits directly upstream of the ATM transaction FSM. It collects a 3-digit BCD account number and a 3-digit BCD PIN from a one-key-per-cycle keypad stream and presents them as 12-bit words. It also enforces a PIN retry limit with lockout, an inactivity timeout and card eject. Downstream consumes `acct_number`, `pin` and `pin_valid`, and returns `auth_done` and `auth_ok`.

## Interface
- `TIMEOUT_CYCLES`, default 1000: inactivity limit in ACCT/PIN, in clocks (≥2).
- `MAX_TRIES`, default 3: wrong-PIN attempts before lockout (1..7).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `card_in` in 1: card present (level).
- `key_valid` in 1: `key_code` valid this cycle.
- `key_code` in 4: 0–9 digit; A clear; B backspace; C enter; D cancel; E/F ignored.
- `auth_done` in 1: one-cycle verdict strobe from the downstream FSM.
- `auth_ok` in 1: PIN accepted; sampled only with `auth_done`.
- `acct_number` out 12: latched account, BCD, first digit in [11:8].
- `pin` out 12: latched PIN, BCD.
- `acct_valid` out 1: level; account latched for this session.
- `pin_valid` out 1: one-cycle pulse on PIN submission.
- `session_active` out 1: level; authorised session open.
- `card_eject` out 1: level; card being returned.
- `locked` out 1: level; card retained after too many wrong PINs.
- `digit_count` out 2: digits currently in the entry buffer (0..3).

## Operation
- States: IDLE, ACCT, PIN, WAIT_AUTH, SESSION, EJECT, LOCKED.
- **Reset:** state IDLE; all outputs 0; buffer, retry counter and timer cleared.
- **IDLE:** rising edge of `card_in` → ACCT. Keys are ignored.
- **Entry buffer (ACCT and PIN):**
  - Digit with count<3: shift the buffer left one nibble, insert the digit into [3:0], count+1.
  - Digit with count=3: ignored.
  - B: shift right one nibble, count−1. No effect at 0.
  - A: buffer and count cleared.
- **Enter in ACCT:**
  - count=3: `acct_number` ← buffer, `acct_valid` ← 1, buffer cleared, → PIN.
  - count<3: ignored.
- **Enter in PIN:**
  - count=3: `pin` ← buffer, `pin_valid` pulses, buffer cleared, → WAIT_AUTH.
  - count<3: ignored.
- **WAIT_AUTH** (keys other than D are ignored):
  - `auth_done` & `auth_ok`: → SESSION, retry counter cleared, `pin` ← 0.
  - `auth_done` & !`auth_ok`: retry+1. If the new value equals `MAX_TRIES` → LOCKED, else → PIN. Either way `pin` ← 0.
- **SESSION:** `session_active`=1. Leaves on D or on `card_in` fall.
- **Cancel (D)** in ACCT, PIN, WAIT_AUTH or SESSION → EJECT.
- **Timeout:**
  - The timer counts every cycle in ACCT/PIN and clears on any `key_valid` or on state entry.
  - Reaching `TIMEOUT_CYCLES`−1 → EJECT.
- **EJECT:**
  - `card_eject`=1.
  - On entry: `acct_valid`, `acct_number`, `pin` and buffer are cleared, and the retry counter is cleared.
  - `card_in` low → IDLE.
- **`card_in` fall** in ACCT, PIN, WAIT_AUTH or SESSION → IDLE directly, with the same clearing as EJECT.
- **LOCKED:**
  - `locked`=1, `card_eject`=0, all keys and `card_in` ignored.
  - `acct_number` and `pin` cleared.
  - Exits only via `rst_n`.
- **Priority within one cycle** (highest first): `card_in` fall, cancel key, `auth_done`, valid key, timeout.

## Timing
- All outputs are registered. Effects appear on the clock edge after the sampling edge.
- Enter accepted at edge N:
  - `acct_valid` high from N+1.
  - `pin_valid` high during the cycle N→N+1 only.
- `auth_done` at edge N: state and `pin` update at N+1. `pin_valid` never re-pulses without a new enter.
- `digit_count` reflects the buffer after each key, one cycle later.
- Timeout: with no keys, EJECT is entered exactly `TIMEOUT_CYCLES` cycles after ACCT/PIN entry.
- `rst_n` assertion mid-operation clears everything immediately. The `card_in` edge detector resets to 0, so a card already present at reset release is treated as a new insertion.

## Structure
- Package `atm_pkg`:
  - key code localparams (KEY_CLEAR, KEY_BACK, KEY_ENTER, KEY_CANCEL);
  - entry state encoding (3-bit);
  - DIGITS=3;
  - WORD_W=12, shared with the transaction FSM.
- Sub-module `atm_digit_buffer`: 3-nibble shift buffer with count, driven by push, pop and clear strobes.
- FSM, timer, retry counter and output registers live in the top module.

## Test plan
- **Happy path:** card_in↑; keys 1,2,3,C,4,5,6,C; then auth_done&auth_ok → `acct_number`=0x123, `pin_valid` one pulse with `pin`=0x456, `session_active`=1; then D → `card_eject`=1, and card_in↓ → IDLE.
- **Edit keys:** keys 7,8,B,9,9,9(4th digit),C → `acct_number`=0x799, `digit_count` sequence 1,2,1,2,3,3. Keys C with 2 digits, then A → no state change, count 0.
- **Lockout:** with `MAX_TRIES`=3, three wrong PINs (auth_ok=0) → PIN, PIN, then LOCKED with `locked`=1, `card_eject`=0. card_in↓ is ignored. rst_n low → all outputs 0.
- **Timeout:** `TIMEOUT_CYCLES`=20, card_in↑ then no keys → `card_eject` rises exactly 20 cycles after ACCT entry. A digit key at cycle 15 delays the eject to cycle 35.
- **Simultaneous events:** in WAIT_AUTH, D together with auth_done&auth_ok → EJECT, `session_active` stays 0. card_in↓ together with key C → IDLE.
- **Reset mid-PIN:** rst_n low after 2 PIN digits → state IDLE and all outputs 0 asynchronously (before the next clock edge). After release, a held card starts ACCT.
